// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - icache request/response and decode handoff signals of the fetch stage
// The fetch stage itself is the slave; the icache/decode environment is the master.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

interface fetch_stage_if #(
  parameter int ADDR = `AddrWidth,
  parameter int INST = `InstWidth
);
  logic            ic_e_;
  logic [ADDR-1:0] ic_pc;
  logic [INST-1:0] ic_inst;
  logic            fetch_e_;
  logic [ADDR-1:0] fetch_pc;
  logic            dec_jump_;
  logic            dec_branch_;
  logic [ADDR-1:0] dec_target;
  logic            dec_stall_;
  logic            inst_e_;
  logic [ADDR-1:0] inst_pc;
  logic [INST-1:0] inst;

  modport slave (
    input  ic_e_, ic_pc, ic_inst, dec_jump_, dec_branch_, dec_target, dec_stall_,
    output fetch_e_, fetch_pc, inst_e_, inst_pc, inst
  );

  modport master (
    output ic_e_, ic_pc, ic_inst, dec_jump_, dec_branch_, dec_target, dec_stall_,
    input  fetch_e_, fetch_pc, inst_e_, inst_pc, inst
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch with a 2-entry skid FIFO to decode
// All control signals are active-low; a decode redirect flushes the FIFO and reloads the PC.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module fetch_stage #(
  parameter int              ADDR     = `AddrWidth,
  parameter int              INST     = `InstWidth,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset_,
  fetch_stage_if.slave   bus
);

  localparam logic [ADDR-1:0] PC_STEP = ADDR'(INST / 8);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR-1:0] pc_q, pc_d;
  logic [1:0]      count_q, count_d;
  logic [ADDR-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [INST-1:0] in0_q, in0_d, in1_q, in1_d;

  logic redirect;
  logic resp;
  logic hit;
  logic req;
  logic push;
  logic pop;
  logic head_valid;

  assign redirect   = !bus.dec_jump_ || !bus.dec_branch_;
  assign resp       = !bus.ic_e_;
  assign hit        = resp && (bus.ic_pc == pc_q);
  assign head_valid = (count_q != 2'd0);
  assign pop        = head_valid && bus.dec_stall_ && !redirect;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      pc0_q   <= '0;
      pc1_q   <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = bus.dec_target;
        end else if (count_q != 2'd2) begin
          req     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect without a response leaves one reply in flight that must be swallowed.
        if (redirect) begin
          pc_d    = bus.dec_target;
          state_d = resp ? S_REQ : S_DROP;
        end else if (hit) begin
          push    = 1'b1;
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_d = bus.dec_target;
        end
        if (resp) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        pc0_d = pc1_q;
        in0_d = in1_q;
      end
      // The free slot after an optional pop is entry 0 when the FIFO holds nothing else.
      if (push) begin
        if ((count_q == 2'd0) || (pop && (count_q == 2'd1))) begin
          pc0_d = pc_q;
          in0_d = bus.ic_inst;
        end else begin
          pc1_d = pc_q;
          in1_d = bus.ic_inst;
        end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.fetch_e_ = !(req && reset_);
  assign bus.fetch_pc = pc_q;
  assign bus.inst_e_  = !head_valid;
  assign bus.inst_pc  = head_valid ? pc0_q : '0;
  assign bus.inst     = head_valid ? in0_q : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed bench for fetch_stage against a queue-level model
// The model tracks the in-order instruction stream, the one icache request in flight and the FIFO contents.
`timescale 1ns/1ps

module tb_fetch_stage;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic reset_;

  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR(32), .INST(32)) bus ();
  fetch_stage_if #(.ADDR(32), .INST(32)) bus2 ();

  fetch_stage #(.ADDR(32), .INST(32), .RESET_PC(32'h0)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  fetch_stage #(.ADDR(32), .INST(32), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus2)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q[$];
  bit          pending;
  bit          pend_ok;
  logic [31:0] pend_pc;
  logic [31:0] next_fetch;
  int          ic_due;
  int          ic_lat;
  int          cyc;
  int          first_valid;
  int          n_pop;
  bit          stray_en;
  logic [31:0] stray_pc;
  logic [31:0] req_pc[$];
  int          req_cyc[$];
  logic [31:0] deliv_pc[$];

  bit          p2;
  logic [31:0] p2pc;
  int          n2;
  logic [31:0] req2[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    bus.ic_e_       = 1'b1;
    bus.ic_pc       = '0;
    bus.ic_inst     = '0;
    bus.dec_jump_   = 1'b1;
    bus.dec_branch_ = 1'b1;
    bus.dec_target  = '0;
    bus.dec_stall_  = 1'b1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    idle_inputs();
    q.delete();
    pending    = 1'b0;
    pend_ok    = 1'b0;
    next_fetch = 32'h0;
    ic_due     = 0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_fetch_e_", 32'(bus.fetch_e_), 32'd1);
    check_eq("rst_fetch_pc", bus.fetch_pc, 32'h0);
    check_eq("rst_inst_e_", 32'(bus.inst_e_), 32'd1);
    check_eq("rst_inst_pc", bus.inst_pc, 32'h0);
    check_eq("rst_inst", bus.inst, 32'h0);
    @(negedge clk);
    reset_      = 1'b1;
    cyc         = 0;
    first_valid = -1;
    req_pc.delete();
    req_cyc.delete();
    deliv_pc.delete();
  endtask

  // One clock cycle: drive at the falling edge, check settled outputs, advance the model to the next rising edge.
  task automatic step(input logic stall_n, input logic jmp_n, input logic br_n, input logic [31:0] tgt);
    logic        redir;
    logic        resp;
    logic [31:0] head;
    resp = pending && (ic_due == 1);
    bus.dec_stall_  = stall_n;
    bus.dec_jump_   = jmp_n;
    bus.dec_branch_ = br_n;
    bus.dec_target  = tgt;
    if (resp) begin
      bus.ic_e_   = 1'b0;
      bus.ic_pc   = pend_pc;
      bus.ic_inst = pend_pc ^ 32'hFFFF_FFFF;
    end else if (stray_en) begin
      bus.ic_e_   = 1'b0;
      bus.ic_pc   = stray_pc;
      bus.ic_inst = $urandom;
    end else begin
      bus.ic_e_   = 1'b1;
      bus.ic_pc   = $urandom;
      bus.ic_inst = $urandom;
    end
    #1;
    redir = !jmp_n || !br_n;
    if (q.size() == 0) begin
      check_eq("inst_e_", 32'(bus.inst_e_), 32'd1);
    end else begin
      head = q[0];
      check_eq("inst_e_", 32'(bus.inst_e_), 32'd0);
      check_eq("inst_pc", bus.inst_pc, head);
      check_eq("inst", bus.inst, head ^ 32'hFFFF_FFFF);
    end
    if (!bus.inst_e_ && first_valid < 0) first_valid = cyc;
    check_eq("fetch_e_", 32'(bus.fetch_e_), (!pending && q.size() < 2 && !redir) ? 32'd0 : 32'd1);
    if (!bus.fetch_e_) begin
      check_eq("fetch_pc", bus.fetch_pc, next_fetch);
      req_pc.push_back(bus.fetch_pc);
      req_cyc.push_back(cyc);
    end
    if (q.size() > 0 && stall_n && !redir) begin
      deliv_pc.push_back(q.pop_front());
      n_pop++;
    end
    if (resp) begin
      pending = 1'b0;
      if (pend_ok && !redir) begin
        q.push_back(pend_pc);
        next_fetch = pend_pc + 32'd4;
      end
    end else if (pending) begin
      ic_due--;
    end
    if (redir) begin
      q.delete();
      next_fetch = tgt;
      pend_ok    = 1'b0;
    end
    if (!bus.fetch_e_) begin
      pending = 1'b1;
      pend_ok = 1'b1;
      pend_pc = bus.fetch_pc;
      ic_due  = ic_lat;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Second instance: 1-cycle icache, no decode activity, records its first two request addresses.
  initial begin
    p2 = 1'b0;
    p2pc = '0;
    n2 = 0;
    bus2.ic_e_ = 1'b1;
    bus2.ic_pc = '0;
    bus2.ic_inst = '0;
    bus2.dec_jump_ = 1'b1;
    bus2.dec_branch_ = 1'b1;
    bus2.dec_target = '0;
    bus2.dec_stall_ = 1'b1;
    forever begin
      @(negedge clk);
      bus2.ic_e_   = !p2;
      bus2.ic_pc   = p2pc;
      bus2.ic_inst = ~p2pc;
      #1;
      p2 = 1'b0;
      if (!bus2.fetch_e_) begin
        p2   = 1'b1;
        p2pc = bus2.fetch_pc;
        if (n2 < 2) req2[n2] = bus2.fetch_pc;
        n2++;
      end
    end
  end

  initial begin
    bit found;
    stray_en = 1'b0;
    stray_pc = '0;
    ic_lat   = 1;
    n_pop    = 0;
    cyc      = 0;
    idle_inputs();

    // Back-to-back fetch with a 1-cycle icache.
    do_reset();
    ic_lat = 1;
    repeat (8) step(1'b1, 1'b1, 1'b1, 32'h0);
    check_eq("p1_first_valid", 32'(first_valid), 32'd2);
    check_eq("p1_nreq", 32'(req_cyc.size() >= 3), 32'd1);
    check_eq("p1_req_cyc1", 32'(req_cyc[1]), 32'd2);
    check_eq("p1_req_cyc2", 32'(req_cyc[2]), 32'd4);
    check_eq("p1_req_pc2", req_pc[2], 32'h8);
    check_eq("p1_ndeliv", 32'(deliv_pc.size() >= 3), 32'd1);
    check_eq("p1_deliv0", deliv_pc[0], 32'h0);
    check_eq("p1_deliv1", deliv_pc[1], 32'h4);
    check_eq("p1_deliv2", deliv_pc[2], 32'h8);
    check_eq("wrap_nreq", 32'(n2 >= 2), 32'd1);
    check_eq("wrap_req0", req2[0], WRAP_PC);
    check_eq("wrap_req1", req2[1], 32'h0);

    // Decode stall fills the FIFO, then drains in order.
    do_reset();
    repeat (6) step(1'b0, 1'b1, 1'b1, 32'h0);
    check_eq("stall_inst_e_", 32'(bus.inst_e_), 32'd0);
    check_eq("stall_inst_pc", bus.inst_pc, 32'h0);
    check_eq("stall_fetch_e_", 32'(bus.fetch_e_), 32'd1);
    repeat (6) step(1'b1, 1'b1, 1'b1, 32'h0);
    check_eq("stall_deliv0", deliv_pc[0], 32'h0);
    check_eq("stall_deliv1", deliv_pc[1], 32'h4);

    // Jump while waiting on the pc 8 response.
    do_reset();
    ic_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b1, 1'b1, 1'b1, 32'h0);
      if (pending && pend_pc == 32'h8) found = 1'b1;
    end
    check_eq("jump_reach_pc8", 32'(found), 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h100);
    check_eq("jump_inst_e_", 32'(bus.inst_e_), 32'd1);
    req_pc.delete();
    deliv_pc.delete();
    for (int i = 0; i < 20 && deliv_pc.size() == 0; i++) step(1'b1, 1'b1, 1'b1, 32'h0);
    check_eq("jump_req0", req_pc[0], 32'h100);
    check_eq("jump_deliv0", deliv_pc[0], 32'h100);

    // Branch coinciding with the icache response.
    do_reset();
    ic_lat = 1;
    step(1'b1, 1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h40);
    check_eq("br_inst_e_", 32'(bus.inst_e_), 32'd1);
    req_pc.delete();
    repeat (4) step(1'b1, 1'b1, 1'b1, 32'h0);
    check_eq("br_req0", req_pc[0], 32'h40);

    // Reset in the middle of a wait, followed by a stale icache reply.
    do_reset();
    ic_lat = 3;
    step(1'b1, 1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0);
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'h0);
    stray_en = 1'b1;
    stray_pc = 32'h20;
    step(1'b1, 1'b1, 1'b1, 32'h0);
    stray_en = 1'b0;
    check_eq("rst_stray_inst_e_", 32'(bus.inst_e_), 32'd1);
    repeat (6) step(1'b1, 1'b1, 1'b1, 32'h0);
    check_eq("rst_deliv0", deliv_pc[0], 32'h0);

    // Random mix of latency, stalls and redirects.
    do_reset();
    n_pop = 0;
    for (int i = 0; i < 1500; i++) begin
      logic        st;
      logic        jn;
      logic        bn;
      logic [31:0] tg;
      ic_lat = $urandom_range(1, 3);
      st = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
      jn = 1'b1;
      bn = 1'b1;
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) jn = 1'b0;
        else bn = 1'b0;
      end
      tg = $urandom & 32'hFFFF_FFFC;
      step(st, jn, bn, tg);
    end
    check_eq("rand_progress", 32'(n_pop > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR, default `AddrWidth (32), SHALL set the width of every address port and of the PC.
REQ-002 Parameter INST, default `InstWidth (32), SHALL set the instruction width; the PC increment is INST/8.
REQ-003 Parameter RESET_PC, default 0, SHALL be the first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_  input  1  asynchronous, active-low reset.
REQ-006 ic_e_  input  1  active-low; icache response valid this cycle.
REQ-007 ic_pc  input  ADDR  address of the returned instruction.
REQ-008 ic_inst  input  INST  returned instruction.
REQ-009 fetch_e_  output  1  active-low, one-cycle fetch request to the icache.
REQ-010 fetch_pc  output  ADDR  request address.
REQ-011 dec_jump_, dec_branch_  input  1 each  active-low redirect from decode; either asserted counts as a redirect.
REQ-012 dec_target  input  ADDR  redirect address.
REQ-013 dec_stall_  input  1  active-low; decode cannot accept an instruction this cycle.
REQ-014 inst_e_  output  1  active-low; inst/inst_pc valid to decode.
REQ-015 inst_pc  output  ADDR  PC of the presented instruction.
REQ-016 inst  output  INST  presented instruction.

Function
REQ-017 The block SHALL hold a PC register, a 2-entry FIFO of {pc, inst} and an FSM with states REQ, WAIT and DROP.
REQ-018 REQ: when FIFO count < 2 and no redirect, drive fetch_e_=0 and fetch_pc=PC for one cycle, then go to WAIT; otherwise keep fetch_e_=1 and stay in REQ.
REQ-019 WAIT: on ic_e_=0 with ic_pc==PC, push {PC, ic_inst}, set PC=PC+INST/8 modulo 2^ADDR and go to REQ; a response with ic_pc!=PC SHALL be ignored.
REQ-020 At most one request SHALL be outstanding, and fetch_e_ SHALL never be asserted outside REQ.
REQ-021 A redirect in any state SHALL flush the FIFO (count=0) and load PC=dec_target at the same edge.
REQ-022 Redirect in REQ SHALL suppress that cycle's request; the FSM stays in REQ.
REQ-023 Redirect in WAIT with no response that cycle SHALL go to DROP.
REQ-024 Redirect in WAIT coinciding with ic_e_=0 SHALL discard the response, perform no push and go to REQ.
REQ-025 DROP: the next ic_e_=0 SHALL be discarded with no push, then go to REQ; a further redirect in DROP SHALL update PC and stay in DROP.
REQ-026 inst_e_, inst_pc and inst SHALL be driven from the FIFO head: inst_e_=0 iff count>0.
REQ-027 The head SHALL pop at the edge where inst_e_=0, dec_stall_=1 and no redirect.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; push at count=2 SHALL not occur by construction (REQ-018).
REQ-029 Minimum latency SHALL be: request in cycle N, response in N+1, inst_e_=0 in N+2.
REQ-030 Sustained throughput with a 1-cycle icache and no stall SHALL be one instruction per 2 cycles.

Reset
REQ-031 While reset_=0: state=REQ, PC=RESET_PC, FIFO count=0, fetch_e_=1, fetch_pc=RESET_PC, inst_e_=1, inst_pc=0, inst=0.
REQ-032 Reset asserted mid-WAIT SHALL abandon the outstanding request; a late icache response after reset release SHALL be ignored by the ic_pc check unless it matches RESET_PC.
REQ-033 The first request SHALL be issued in the first clock cycle after reset_ rises.

Verification
REQ-034 Reset release, 1-cycle icache returning inst=pc^32'hFFFF_FFFF -> fetch_pc 0,4,8 on alternate cycles; decode sees inst_pc 0,4,8 in order.
REQ-035 dec_stall_=0 held for 6 cycles -> FIFO fills to 2 (pc 0,4), fetch_e_ stays 1, inst_pc held at 0; release -> 0 then 4 delivered with no loss or duplicate.
REQ-036 dec_jump_=0 with target 0x100 while in WAIT for pc 8 -> response for 8 dropped, inst_e_=1 next cycle, next fetch_pc=0x100, next delivered inst_pc=0x100.
REQ-037 dec_branch_=0 with target 0x40 in the same cycle as ic_e_=0 -> no push, next fetch_pc=0x40.
REQ-038 RESET_PC=32'hFFFF_FFFC -> fetch_pc FFFF_FFFC then 0000_0000 (wrap-around).
REQ-039 reset_ pulsed low during WAIT with the icache responding 2 cycles later at pc 0x20 -> response ignored, outputs at reset values, fetch restarts at RESET_PC.
